// File: rtl/reg_dump_if.sv
// Beat stream carrying dumped register contents from reg_dump to its consumer.
interface reg_dump_if;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/reg_dump.sv
// Dumps an inclusive register range as a valid/ready beat stream, reading two registers per pass
// through the register file's two combinational read ports.
module reg_dump (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        first_reg,
    input  logic [4:0]        last_reg,
    output logic [4:0]        rd_reg_1,
    output logic [4:0]        rd_reg_2,
    input  logic [31:0]       rd_data_1,
    input  logic [31:0]       rd_data_2,
    reg_dump_if.master        dump,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StSend0,
        StSend1,
        StDone
    } state_e;

    state_e      state;
    logic [4:0]  cur;
    logic [4:0]  last;
    logic [31:0] buf0;
    logic [31:0] buf1;
    logic        pair;

    // All outputs are registered and set on the transition into the state that presents them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            cur            <= 5'd0;
            last           <= 5'd0;
            buf0           <= 32'd0;
            buf1           <= 32'd0;
            pair           <= 1'b0;
            rd_reg_1       <= 5'd0;
            rd_reg_2       <= 5'd0;
            dump.out_valid <= 1'b0;
            dump.out_addr  <= 5'd0;
            dump.out_data  <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (first_reg <= last_reg) begin
                            cur      <= first_reg;
                            last     <= last_reg;
                            rd_reg_1 <= first_reg;
                            rd_reg_2 <= first_reg + 5'd1;
                            state    <= StRead;
                        end else begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StRead: begin
                    rd_reg_1 <= 5'd0;
                    rd_reg_2 <= 5'd0;
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        buf0 <= rd_data_1;
                        pair <= (cur < last);
                        if (cur < last) begin
                            buf1 <= rd_data_2;
                        end
                        dump.out_valid <= 1'b1;
                        dump.out_addr  <= cur;
                        dump.out_data  <= rd_data_1;
                        state          <= StSend0;
                    end
                end
                StSend0: begin
                    if (abort) begin
                        dump.out_valid <= 1'b0;
                        dump.out_addr  <= 5'd0;
                        dump.out_data  <= 32'd0;
                        busy           <= 1'b0;
                        state          <= StIdle;
                    end else if (dump.out_ready) begin
                        if (pair) begin
                            dump.out_addr <= cur + 5'd1;
                            dump.out_data <= buf1;
                            state         <= StSend1;
                        end else begin
                            dump.out_valid <= 1'b0;
                            dump.out_addr  <= 5'd0;
                            dump.out_data  <= 32'd0;
                            done           <= 1'b1;
                            state          <= StDone;
                        end
                    end
                end
                StSend1: begin
                    if (abort) begin
                        dump.out_valid <= 1'b0;
                        dump.out_addr  <= 5'd0;
                        dump.out_data  <= 32'd0;
                        busy           <= 1'b0;
                        state          <= StIdle;
                    end else if (dump.out_ready) begin
                        dump.out_valid <= 1'b0;
                        dump.out_addr  <= 5'd0;
                        dump.out_data  <= 32'd0;
                        // Widened compare so a range ending at 31 terminates instead of wrapping.
                        if (({1'b0, cur} + 6'd1) == {1'b0, last}) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            cur      <= cur + 5'd2;
                            rd_reg_1 <= cur + 5'd2;
                            rd_reg_2 <= cur + 5'd3;
                            state    <= StRead;
                        end
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: table of dump ranges plus hand-written stall, abort and reset cases.
module tb_reg_dump;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  rd_reg_1;
    logic [4:0]  rd_reg_2;
    logic [31:0] rd_data_1;
    logic [31:0] rd_data_2;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int failures;

    reg_dump_if dump ();

    reg_dump dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rd_reg_1  (rd_reg_1),
        .rd_reg_2  (rd_reg_2),
        .rd_data_1 (rd_data_1),
        .rd_data_2 (rd_data_2),
        .dump      (dump),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Register file model: r[i] = i * 0x11.
    assign rd_data_1 = 32'(rd_reg_1) * 32'h11;
    assign rd_data_2 = 32'(rd_reg_2) * 32'h11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] first;
        logic [4:0] last;
        int         beats;
        int         done_cyc;
        logic       err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a dump and follows it to done, checking every cycle against a simple model.
    task automatic run_dump(input logic [4:0] first, input logic [4:0] last, input int exp_beats,
                            input int exp_done, input logic exp_err, input int stall_addr,
                            input int stall_len);
        int         cyc;
        int         nbeats;
        int         stalled;
        logic [4:0] exp_addr;
        bit         finished;
        first_reg = first;
        last_reg  = last;
        start     = 1'b1;
        dump.out_ready = 1'b1;
        step();
        start    = 1'b0;
        cyc      = 1;
        nbeats   = 0;
        stalled  = 0;
        finished = 1'b0;
        while (!finished && cyc < 200) begin
            exp_addr = first + 5'(nbeats);
            check("busy", {31'd0, busy}, 32'd1);
            if (!done) check("err_without_done", {31'd0, err}, 32'd0);
            if (dump.out_valid) begin
                check("beat_addr", {27'd0, dump.out_addr}, {27'd0, exp_addr});
                check("beat_data", dump.out_data, 32'(exp_addr) * 32'h11);
                if (int'(dump.out_addr) == stall_addr && stalled < stall_len) begin
                    dump.out_ready = 1'b0;
                    stalled++;
                end else begin
                    dump.out_ready = 1'b1;
                    nbeats++;
                end
            end else begin
                dump.out_ready = 1'b1;
                check("idle_addr", {27'd0, dump.out_addr}, 32'd0);
                check("idle_data", dump.out_data, 32'd0);
                if (!done) begin
                    check("rd_reg_1", {27'd0, rd_reg_1}, {27'd0, exp_addr});
                    check("rd_reg_2", {27'd0, rd_reg_2}, {27'd0, exp_addr + 5'd1});
                end
            end
            if (done) begin
                finished = 1'b1;
                check("done_cycle", cyc, exp_done);
                check("done_err", {31'd0, err}, {31'd0, exp_err});
                check("beat_count", nbeats, exp_beats);
            end else begin
                step();
                cyc++;
            end
        end
        if (!finished) begin
            failures++;
            $display("FAIL done_timeout: no done within %0d cycles", cyc);
        end
        dump.out_ready = 1'b1;
        step();
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    // Waits (bounded) until a beat with the given address is presented.
    task automatic wait_beat(input logic [4:0] addr, output bit found);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (dump.out_valid && dump.out_addr == addr) found = 1'b1;
            else step();
        end
        if (!found) begin
            failures++;
            $display("FAIL wait_beat_timeout: addr %0d never presented", addr);
        end
    endtask

    initial begin
        bit found;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        first_reg = 5'd0;
        last_reg  = 5'd0;
        dump.out_ready = 1'b1;

        vecs[0] = '{first: 5'd0,  last: 5'd31, beats: 32, done_cyc: 49, err: 1'b0};
        vecs[1] = '{first: 5'd3,  last: 5'd5,  beats: 3,  done_cyc: 6,  err: 1'b0};
        vecs[2] = '{first: 5'd9,  last: 5'd4,  beats: 0,  done_cyc: 1,  err: 1'b1};
        vecs[3] = '{first: 5'd7,  last: 5'd7,  beats: 1,  done_cyc: 3,  err: 1'b0};
        vecs[4] = '{first: 5'd30, last: 5'd31, beats: 2,  done_cyc: 4,  err: 1'b0};
        vecs[5] = '{first: 5'd31, last: 5'd31, beats: 1,  done_cyc: 3,  err: 1'b0};
        vecs[6] = '{first: 5'd0,  last: 5'd0,  beats: 1,  done_cyc: 3,  err: 1'b0};
        vecs[7] = '{first: 5'd10, last: 5'd13, beats: 4,  done_cyc: 7,  err: 1'b0};

        step();
        step();
        check("rst_valid", {31'd0, dump.out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rd_reg_1", {27'd0, rd_reg_1}, 32'd0);
        check("rst_rd_reg_2", {27'd0, rd_reg_2}, 32'd0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            run_dump(vecs[i].first, vecs[i].last, vecs[i].beats, vecs[i].done_cyc, vecs[i].err,
                     -1, 0);
        end

        // Backpressure on addr 7 for 4 cycles delays done by 4.
        run_dump(5'd0, 5'd31, 32, 53, 1'b0, 7, 4);

        // Invalid range, with a valid start held during the DONE cycle (must be ignored).
        first_reg = 5'd9;
        last_reg  = 5'd4;
        start     = 1'b1;
        step();
        check("inv_done", {31'd0, done}, 32'd1);
        check("inv_err", {31'd0, err}, 32'd1);
        check("inv_valid", {31'd0, dump.out_valid}, 32'd0);
        first_reg = 5'd1;
        last_reg  = 5'd2;
        step();
        start = 1'b0;
        check("inv_busy_once", {31'd0, busy}, 32'd0);
        check("inv_done_once", {31'd0, done}, 32'd0);
        step();
        check("done_start_ignored", {31'd0, busy}, 32'd0);

        // Abort while addr 11 sits in SEND1.
        first_reg = 5'd0;
        last_reg  = 5'd31;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_beat(5'd11, found);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_valid", {31'd0, dump.out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        step();
        check("abort_no_late_done", {31'd0, done}, 32'd0);
        run_dump(5'd30, 5'd31, 2, 4, 1'b0, -1, 0);

        // Reset during SEND0 of addr 2, with a start in the same cycle.
        first_reg = 5'd0;
        last_reg  = 5'd31;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_beat(5'd2, found);
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check("mid_rst_valid", {31'd0, dump.out_valid}, 32'd0);
        check("mid_rst_addr", {27'd0, dump.out_addr}, 32'd0);
        check("mid_rst_data", dump.out_data, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_rd_reg_1", {27'd0, rd_reg_1}, 32'd0);
        step();
        check("rst_start_ignored", {31'd0, busy}, 32'd0);
        check("mid_rst_no_done", {31'd0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
